serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder per clock, LSB first, with a
// registered carry fed back into the adder and a one-cycle done pulse.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_sh_q, acc_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             fa_sum, fa_carry;
    logic [WIDTH-1:0] acc_next;

    fulladder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New bit enters at the MSB so bit 0 lands at the LSB after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_acc1
            assign acc_next = fa_sum;
        end else begin : g_accn
            assign acc_next = {fa_sum, acc_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_sh_d = acc_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_sh_d = acc_next;
                carry_d  = fa_carry;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = acc_next;
                    cout_d  = fa_carry;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_sh_q <= acc_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   busy_len = 0;
    int   last_done = -1;
    bit   done_prev = 1'b0;
    bit   b2b_mode = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: scoreboard compare, busy run length, done width and spacing.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done) begin
            if (exp_q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", cyc);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_sum"}, 32'(sum), 32'(e.sum));
                check({e.name, "_cout"}, 32'(cout), 32'(e.cout));
                check({e.name, "_busy_len"}, 32'(busy_len), 32'(W));
                check({e.name, "_busy_in_done"}, 32'(busy), 32'd0);
            end
            if (done_prev) begin
                nvec++; nerr++;
                $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
            end
            if (b2b_mode && last_done >= 0)
                check("b2b_spacing", 32'(cyc - last_done), 32'(W + 2));
            last_done = cyc;
        end
        busy_len  = busy ? busy_len + 1 : 0;
        done_prev = done;
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                         input logic [W-1:0] es, input logic ec, input string name);
        exp_t e;
        @(posedge clk); #1;
        a = av; b = bv; cin = c; start = 1'b1;
        e.sum = es; e.cout = ec; e.name = name;
        exp_q.push_back(e);
        @(posedge clk); #1;   // accepting edge E0
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL %s_timeout: %0d results still pending", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        // 1. Reset
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_sum", 32'(sum), 32'd0);

        // 2-3. Basic and carry chain
        issue(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "basic");         drain("basic");
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_1");     drain("ff_plus_1");
        issue(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a_cin");     drain("a5_5a_cin");
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_cin");     drain("ff_ff_cin");

        // 4. Start while busy and in DONE is ignored
        issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "ignore_start");  // now just after E0
        repeat (2) @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF; start = 1'b1;                      // sampled at E3 in RUN
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk); #1;                           // just after E8: DONE
        start = 1'b1;
        @(posedge clk); #1;                                      // E9 sees DONE, ignores start
        start = 1'b0;
        drain("ignore_start");
        repeat (12) @(posedge clk);                              // any stray done is flagged

        // 5. Reset mid-operation
        @(posedge clk); #1;
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #2;                           // inside RUN cycle 4
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        issue(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_rst");     drain("after_rst");

        // 6. Back-to-back with start held high: accepts at E0, E10, E20
        b2b_mode = 1'b1;
        last_done = -1;
        @(posedge clk); #1;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.sum = 8'h02; e.cout = 1'b0; e.name = $sformatf("b2b%0d", i);
            exp_q.push_back(e);
        end
        repeat (21) @(posedge clk); #1;                          // through E20
        start = 1'b0;
        drain("b2b");
        b2b_mode = 1'b0;
        repeat (12) @(posedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
